// File: rtl/hack_cpu_ws.sv
// hack_cpu_ws: multi-cycle Hack-ISA core with a one-entry fetch buffer and a
// req/ack data-memory handshake that tolerates any number of wait states.
//
// Optional build macro: CPU_DEBUG_EN adds halt_req/step/halted debug control.
//
// Ports:
//   clk, resetN            clock, asynchronous active-low reset
//   imem_addr, imem_rdata  fetch word address (pc >> log2(IPW)) and its data,
//                          valid one cycle after the address
//   dmem_req/we/addr/wdata data access request, held until dmem_ack
//   dmem_rdata, dmem_ack   read data and completion strobe
//   retired                one-cycle pulse per committed instruction
//   pc_o                   current program counter
//   halt_req, step, halted debug control (CPU_DEBUG_EN only)
module hack_cpu_ws #(
    parameter int unsigned DW  = 16,
    parameter int unsigned AW  = 10,
    parameter int unsigned IPW = 2,
    parameter int unsigned DAW = 15
) (
    input  logic                      clk,
    input  logic                      resetN,
    output logic [AW-$clog2(IPW)-1:0] imem_addr,
    input  logic [16*IPW-1:0]         imem_rdata,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [DAW-1:0]            dmem_addr,
    output logic [DW-1:0]             dmem_wdata,
    input  logic [DW-1:0]             dmem_rdata,
    input  logic                      dmem_ack,
    output logic                      retired,
`ifdef CPU_DEBUG_EN
    input  logic                      halt_req,
    input  logic                      step,
    output logic                      halted,
`endif
    output logic [AW-1:0]             pc_o
);

    localparam int unsigned IB = $clog2(IPW);

    localparam logic [2:0] StFetch = 3'd0;
    localparam logic [2:0] StExec  = 3'd1;
    localparam logic [2:0] StMrd   = 3'd2;
    localparam logic [2:0] StWgap  = 3'd3;  // one idle cycle so req drops between MRD and MWR
    localparam logic [2:0] StMwr   = 3'd4;
`ifdef CPU_DEBUG_EN
    localparam logic [2:0] StHalt  = 3'd5;
`endif

    logic [2:0]        state_q, state_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic [DW-1:0]     a_q, a_d, d_q, d_d;
    logic [DW-1:0]     aold_q, aold_d;
    logic [12:0]       inst_q, inst_d;
    logic [DW-1:0]     alu_q, alu_d;
    logic [16*IPW-1:0] buf_q, buf_d;
    logic [AW-IB-1:0]  tag_q, tag_d;
    logic              bvalid_q, bvalid_d;

    logic              buf_hit;
    logic [16*IPW-1:0] word;
    logic [15:0]       inst_ex;
    logic [12:0]       cf;
    logic [DW-1:0]     aold_cur;
    logic [DW-1:0]     alu_x, alu_y, alu_out;
    logic              alu_zr, alu_ng, jump;
    logic [AW-1:0]     pc_commit;
    logic              boundary;

    // Right after a FETCH the buffer misses, so the fresh ROM word is used directly.
    assign buf_hit = bvalid_q && (tag_q == pc_q[AW-1:IB]);
    assign word    = buf_hit ? buf_q : imem_rdata;

    generate
        if (IPW == 2) begin : g_sel2
            assign inst_ex = pc_q[0] ? word[31:16] : word[15:0];
        end else begin : g_sel1
            assign inst_ex = word[15:0];
        end
    endgenerate

    // C-instruction fields and A_old: live in EXEC, latched copies afterwards.
    assign cf       = (state_q == StExec) ? inst_ex[12:0] : inst_q;
    assign aold_cur = (state_q == StExec) ? a_q : aold_q;

    always_comb begin
        alu_x = d_q;
        alu_y = cf[12] ? dmem_rdata : aold_cur;
        if (cf[11]) alu_x = '0;
        if (cf[10]) alu_x = ~alu_x;
        if (cf[9])  alu_y = '0;
        if (cf[8])  alu_y = ~alu_y;
        alu_out = cf[7] ? (alu_x + alu_y) : (alu_x & alu_y);
        if (cf[6])  alu_out = ~alu_out;
    end

    assign alu_zr    = (alu_out == '0);
    assign alu_ng    = alu_out[DW-1];
    assign jump      = (cf[2] & alu_ng) | (cf[1] & alu_zr) | (cf[0] & ~alu_ng & ~alu_zr);
    assign pc_commit = jump ? aold_cur[AW-1:0] : pc_q + AW'(1);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        a_d      = a_q;
        d_d      = d_q;
        aold_d   = aold_q;
        inst_d   = inst_q;
        alu_d    = alu_q;
        buf_d    = buf_q;
        tag_d    = tag_q;
        bvalid_d = bvalid_q;
        retired  = 1'b0;
        boundary = 1'b0;

        unique case (state_q)
            StFetch: state_d = StExec;
            StExec: begin
                aold_d = a_q;
                inst_d = inst_ex[12:0];
                if (!buf_hit) begin
                    buf_d    = imem_rdata;
                    tag_d    = pc_q[AW-1:IB];
                    bvalid_d = 1'b1;
                end
                if (!inst_ex[15]) begin
                    a_d      = DW'(inst_ex[14:0]);
                    pc_d     = pc_q + AW'(1);
                    retired  = 1'b1;
                    boundary = 1'b1;
                end else if (inst_ex[12]) begin
                    state_d = StMrd;
                end else begin
                    if (inst_ex[5]) a_d = alu_out;
                    if (inst_ex[4]) d_d = alu_out;
                    pc_d  = pc_commit;
                    alu_d = alu_out;
                    if (inst_ex[3]) begin
                        state_d = StMwr;
                    end else begin
                        retired  = 1'b1;
                        boundary = 1'b1;
                    end
                end
            end
            StMrd: begin
                if (dmem_ack) begin
                    if (inst_q[5]) a_d = alu_out;
                    if (inst_q[4]) d_d = alu_out;
                    pc_d  = pc_commit;
                    alu_d = alu_out;
                    if (inst_q[3]) begin
                        state_d = StWgap;
                    end else begin
                        retired  = 1'b1;
                        boundary = 1'b1;
                    end
                end
            end
            StWgap: state_d = StMwr;
            StMwr: begin
                if (dmem_ack) begin
                    retired  = 1'b1;
                    boundary = 1'b1;
                end
            end
`ifdef CPU_DEBUG_EN
            StHalt: begin
                if (!halt_req || step) boundary = 1'b1;
            end
`endif
            default: state_d = StFetch;
        endcase

        if (boundary) begin
            state_d = (bvalid_d && (tag_d == pc_d[AW-1:IB])) ? StExec : StFetch;
`ifdef CPU_DEBUG_EN
            // A step leaves HALT even with halt_req held; the next boundary halts again.
            if (halt_req && !(state_q == StHalt && step)) state_d = StHalt;
`endif
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= StFetch;
            pc_q     <= '0;
            a_q      <= '0;
            d_q      <= '0;
            aold_q   <= '0;
            inst_q   <= '0;
            alu_q    <= '0;
            buf_q    <= '0;
            tag_q    <= '0;
            bvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            a_q      <= a_d;
            d_q      <= d_d;
            aold_q   <= aold_d;
            inst_q   <= inst_d;
            alu_q    <= alu_d;
            buf_q    <= buf_d;
            tag_q    <= tag_d;
            bvalid_q <= bvalid_d;
        end
    end

    assign imem_addr  = pc_q[AW-1:IB];
    assign dmem_req   = (state_q == StMrd) || (state_q == StMwr);
    assign dmem_we    = (state_q == StMwr);
    assign dmem_addr  = aold_q[DAW-1:0];
    assign dmem_wdata = alu_q;
    assign pc_o       = pc_q;
`ifdef CPU_DEBUG_EN
    assign halted     = (state_q == StHalt);
`endif

endmodule

// File: doc/hack_cpu_ws.md
Name: hack_cpu_ws

Overview:
- Parametrised Hack-ISA CPU core with a multi-cycle FSM and a wait-state data-memory handshake.
- Instruction width is fixed at 16 bits. Data width, PC width and instructions-per-fetch-word are configurable.
- A one-entry fetch buffer skips re-fetching when consecutive instructions share one fetch word.
- Sits between the instruction ROM (synchronous, 1-cycle read) and the data-memory/IO arbiter.

Parameters:
- DW, 16: data width of A, D, ALU and dmem_wdata/rdata; must be >= 16.
- AW, 10: PC width in instructions; PC wraps modulo 2^AW.
- IPW, 2: instructions per fetch word; legal values 1 or 2.
- DAW, 15: data address width; must be <= DW.

Ports:
- clk, in, 1: clock.
- resetN, in, 1: asynchronous active-low reset.
- imem_addr, out, AW-$clog2(IPW): fetch word address, equal to pc>>$clog2(IPW).
- imem_rdata, in, 16*IPW: fetch word. Valid one cycle after imem_addr. Instruction k occupies bits [16k+15:16k].
- dmem_req, out, 1: data access request; held until ack.
- dmem_we, out, 1: 1 for write, 0 for read; stable while req is high.
- dmem_addr, out, DAW: A[DAW-1:0] latched at instruction start.
- dmem_wdata, out, DW: ALU result to store.
- dmem_rdata, in, DW: read data; valid in the ack cycle.
- dmem_ack, in, 1: completes the request. Ignored when req=0. Earliest ack is the cycle after req rises.
- retired, out, 1: 1-cycle pulse when an instruction commits.
- pc_o, out, AW: current PC, for debug.

Behaviour:
Reset (async, resetN=0):
- pc=0, A=0, D=0, state=FETCH, fetch buffer invalid.
- dmem_req=0, dmem_we=0, retired=0.
- Takes effect immediately mid-operation. A pending request is abandoned and no late ack is honoured.

Decode:
- inst[15]=0 (A-instruction): A <= zero-extended inst[14:0].
- inst[15]=1 (C-instruction) fields:
  - a = inst[12]: ALU y operand is M when 1, A when 0.
  - fn = inst[11:6], ordered zx,nx,zy,ny,f,no (standard Hack ALU at DW bits; f=1 add, f=0 AND).
  - dest = inst[5:3], ordered A,D,M.
  - jmp = inst[2:0], ordered lt,eq,gt.
- ALU x operand is D.
- Flags are taken on the ALU output: zr = (out==0), ng = out[DW-1].
- Jump taken if (lt&ng)|(eq&zr)|(gt&!ng&!zr); then pc <= A_old[AW-1:0], else pc <= pc+1.
- Address and jump targets always use A_old, the value before this instruction's write to A.

FSM:
- FETCH: drive imem_addr. Next cycle load imem_rdata into the buffer with its word tag and set it valid; go to EXEC.
- EXEC: select instruction pc[0] (IPW=2) or the whole word (IPW=1). Latch A_old.
  - A-instruction, or C-instruction with a=0 and dest[M]=0: commit this cycle.
  - a=1: go to MRD.
  - a=0 and dest[M]=1: compute the ALU, commit registers and PC, go to MWR.
- MRD: req=1, we=0, addr=A_old. On ack, capture rdata as M, compute the ALU, commit registers and PC. Go to MWR if dest[M]=1, otherwise to next.
- MWR: req=1, we=1, addr=A_old, wdata=latched ALU result. On ack go to next.
- retired pulses in the commit cycle, or in the MWR ack cycle when dest[M]=1.
- Next state: EXEC if the buffer is valid and its tag == new pc>>$clog2(IPW), otherwise FETCH.
- A write to M never changes the buffer; instruction memory is a separate space.

Cycle counts (zero wait states):
- A-instruction or register-only C-instruction: 1 cycle on a buffer hit, 2 on a miss.
- Each data access adds 1 + wait cycles.
- req drops in the cycle after ack. Back-to-back MRD then MWR re-raises req after a 1-cycle gap.

PC and jumps:
- pc+1 wraps modulo 2^AW.
- Any taken jump re-evaluates hit/miss normally; a jump target inside the buffered word is a hit.

Optional Feature:
CPU_DEBUG_EN:
- With the macro defined, adds input halt_req(1), input step(1) and output halted(1).
- When halt_req=1 at an instruction boundary (next-state decision), the core enters HALT: halted=1, no fetch, no data access.
- A 1-cycle step pulse while halted executes exactly one instruction, then returns to HALT.
- Deasserting halt_req resumes from HALT at the next boundary.
- halted resets to 0.
- Without the macro, the ports are absent and the core never halts.

Test Plan:
- Reset with IPW=2: program @0 = 0x0005, D=A (0xEC10) -> word 0 fetched once. Cycle 2: A=5, retired. Cycle 3: D=5, retired, no FETCH between them.
- M=D+1 (0xE7C8) with A=3, D=7, ack delayed 3 cycles -> dmem_req, we=1, addr=3, wdata=8 held 4 cycles. Single retired on the ack cycle.
- AM=M+1 (0xFDE8) with A=3, M=9 -> read of addr 3, then write of 10 to addr 3 (A_old used). A=10 after commit.
- D=-1 (0xEE90), then A=0x20, then D;JLT (0xE304) -> pc=0x20, FETCH issued. With D=0 and JLT, pc increments, no jump.
- Asynchronous reset asserted mid-MRD with req=1 -> req=0 immediately. After release, pc=0 and an ack arriving later is ignored.
- (CPU_DEBUG_EN) halt_req=1 during the stream -> halted=1 within one instruction. Two step pulses -> exactly two retired pulses, pc advanced by 2.
